stack_prog_driver: RTL

STACK_PROG_DRIVER -- requirements
Module: stack_prog_driver

---
 rtl/stack_prog_driver.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/stack_prog_driver.sv
// stack_prog_driver: feeds queued host instructions to a stack_cpu over its
// 4-bit inbits port, keeping the CPU's opcode/operand fetch phase aligned.
// Optional capture of cpu_out after op 3/4 is enabled by defining
// STACK_DRV_CAPTURE_EN (adds cap_valid / cap_data).
//
// state | meaning
// RSTC  | CPU held in reset; 2 cycles after the start-up edge
// NOPF  | NOOP in the CPU opcode slot (never dispatches)
// NOPX  | NOOP in the CPU operand slot; dispatch point
// FETCH | popped opcode on cpu_bits, 1 cycle
// EXEC  | operand on cpu_bits for N cycles; last cycle is a dispatch point
module stack_prog_driver (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_op,
  input  logic [3:0] in_arg,
  output logic       in_ready,
  output logic       cpu_rst,
  output logic [3:0] cpu_bits,
  output logic [1:0] cpu_mode,
  input  logic [7:0] cpu_out,
`ifdef STACK_DRV_CAPTURE_EN
  output logic       cap_valid,
  output logic [7:0] cap_data,
`endif
  output logic       busy,
  output logic [7:0] issued
);

  typedef enum logic [2:0] {RSTC, NOPF, NOPX, FETCH, EXEC} state_t;

  state_t      state_q, state_d;
  logic        rstc_cnt_q, rstc_cnt_d;
  logic [1:0]  exec_cnt_q, exec_cnt_d;
  logic        started_q, started_d;
  logic [7:0]  fifo_q [4];
  logic [7:0]  fifo_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [3:0]  op_q, op_d, arg_q, arg_d;
  logic [7:0]  issued_q, issued_d;
  logic [3:0]  cpu_bits_q, cpu_bits_d;
  logic        push, pop, dispatch;
  logic [7:0]  head;

  // Remaining EXEC cycles after the first one, per opcode.
  function automatic logic [1:0] exec_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8: exec_len = 2'd1;
      4'h9, 4'hA:                         exec_len = 2'd2;
      default:                            exec_len = 2'd0;
    endcase
  endfunction

  assign head     = fifo_q[rd_ptr_q];
  assign push     = in_valid && in_ready;

  // State register plus all datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RSTC;
      rstc_cnt_q <= 1'b1;
      exec_cnt_q <= 2'd0;
      started_q  <= 1'b0;
      fifo_q     <= '{default: 8'h00};
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      op_q       <= 4'd0;
      arg_q      <= 4'd0;
      issued_q   <= 8'd0;
      cpu_bits_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      rstc_cnt_q <= rstc_cnt_d;
      exec_cnt_q <= exec_cnt_d;
      started_q  <= started_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_q       <= op_d;
      arg_q      <= arg_d;
      issued_q   <= issued_d;
      cpu_bits_q <= cpu_bits_d;
    end
  end

  // Next state; dispatch uses the registered count so a same-cycle push is not seen.
  always_comb begin
    state_d    = state_q;
    rstc_cnt_d = rstc_cnt_q;
    exec_cnt_d = exec_cnt_q;
    dispatch   = 1'b0;
    pop        = 1'b0;
    case (state_q)
      RSTC: begin
        if (started_q) begin
          if (rstc_cnt_q == 1'b0) dispatch = 1'b1;
          else                    rstc_cnt_d = rstc_cnt_q - 1'b1;
        end
      end
      NOPF:  state_d = NOPX;
      NOPX:  dispatch = 1'b1;
      FETCH: begin
        state_d    = EXEC;
        exec_cnt_d = exec_len(op_q);
      end
      EXEC: begin
        if (exec_cnt_q == 2'd0) dispatch = 1'b1;
        else                    exec_cnt_d = exec_cnt_q - 2'd1;
      end
      default: state_d = RSTC;
    endcase
    if (dispatch) begin
      if (count_q != 3'd0) begin
        pop     = 1'b1;
        state_d = FETCH;
      end else begin
        state_d = NOPF;
      end
    end
  end

  // FIFO bookkeeping, instruction latch and issue counter.
  always_comb begin
    started_d = 1'b1;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    op_d      = op_q;
    arg_d     = arg_q;
    issued_d  = issued_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {in_op, in_arg};
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d      = rd_ptr_q + 2'd1;
      {op_d, arg_d} = head;
      issued_d      = issued_q + 8'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Outputs; cpu_bits is registered from the value belonging to the next state.
  always_comb begin
    case (state_d)
      FETCH:   cpu_bits_d = head[7:4];
      EXEC:    cpu_bits_d = arg_q;
      default: cpu_bits_d = 4'd0;
    endcase
    cpu_rst  = (state_q == RSTC);
    in_ready = started_q && (count_q != 3'd4);
    busy     = (count_q != 3'd0) || (state_q == FETCH) || (state_q == EXEC);
    cpu_mode = 2'b00;
    cpu_bits = cpu_bits_q;
    issued   = issued_q;
  end

`ifdef STACK_DRV_CAPTURE_EN
  logic       cap_fire;
  logic       cap_valid_q, cap_valid_d;
  logic [7:0] cap_data_q, cap_data_d;

  assign cap_fire = (state_q == EXEC) && (exec_cnt_q == 2'd0) &&
                    ((op_q == 4'd3) || (op_q == 4'd4));

  // Sample the CPU output at the edge that ends the final EXEC cycle of op 3/4.
  always_comb begin
    cap_valid_d = cap_fire;
    cap_data_d  = cap_fire ? cpu_out : cap_data_q;
    cap_valid   = cap_valid_q;
    cap_data    = cap_data_q;
  end

  // Capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_valid_q <= 1'b0;
      cap_data_q  <= 8'h00;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
    end
  end
`else
  logic cpu_out_unused;
  assign cpu_out_unused = ^cpu_out;
`endif

endmodule
